// File: rtl/act_nz_scanner.sv
// act_nz_scanner: walks the zero-flag vector of an activation register file
// and streams out every nonzero activation (index + value), lowest index first,
// over a valid/ready output port. One read and one emitted activation per
// cycle when the consumer keeps out_ready high.
//
// Handshake: an activation is transferred on a rising edge where
// out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0 the payload
// (out_idx, out_data, out_last) holds stable. out_valid never drops without
// a transfer.
module act_nz_scanner #(
  parameter int ACT_NO = 16,
  parameter int ACT_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ACT_NO-1:0] in_act_zeros,
  output logic              in_act_read_en,
  output logic [ACT_W-1:0]  in_act_read_addr,
  input  logic [DATA_W-1:0] in_act_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACT_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [ACT_W:0]    nnz_cnt
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [ACT_NO-1:0] ONE = ACT_NO'(1);

  state_t              state_q, state_d;
  logic [ACT_NO-1:0]   pending_q;
  logic [ACT_NO-1:0]   pending_rest;   // pending with its lowest set bit cleared
  logic [ACT_W-1:0]    low_idx;
  logic [ACT_W:0]      pop_cnt;
  logic                slot_free;      // output register can take a new entry
  logic                issue;
  logic                finish;

  // Lowest set index of pending; later (lower) matches overwrite earlier ones.
  always_comb begin
    low_idx = '0;
    for (int i = ACT_NO - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = ACT_W'(i);
    end
  end

  // Number of nonzero entries in the incoming zero-flag vector.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < ACT_NO; i++) begin
      pop_cnt = pop_cnt + (ACT_W+1)'(~in_act_zeros[i]);
    end
  end

  // Scan control terms; reads are suppressed while reset is asserted.
  always_comb begin
    pending_rest = pending_q & (pending_q - ONE);
    slot_free    = !out_valid || out_ready;
    issue        = !rst && (state_q == SCAN) && (pending_q != '0) && slot_free;
    finish       = (state_q == SCAN) && (pending_q == '0) && slot_free;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = SCAN;
      SCAN:    if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: read port and busy flag.
  always_comb begin
    busy             = (state_q == SCAN);
    in_act_read_en   = issue;
    in_act_read_addr = issue ? low_idx : '0;
  end

  // Pending mask, output register and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      nnz_cnt   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state_q == IDLE) && start) begin
        pending_q <= ~in_act_zeros;
        nnz_cnt   <= pop_cnt;
      end
      if (issue) begin
        pending_q <= pending_rest;
        out_valid <= 1'b1;
        out_idx   <= low_idx;
        out_data  <= in_act_read_data;
        out_last  <= (pending_rest == '0);
      end else if (out_valid && out_ready) begin
        // Transfer with nothing new to show: drop valid and last together so
        // out_last never lingers outside a scan.
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (finish) begin
        done      <= 1'b1;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_act_nz_scanner.sv
// Testbench for act_nz_scanner (ACT_NO=16). Cycle T is the cycle in which
// start is driven; every later cycle is numbered relative to it. Inputs are
// driven just after the falling edge and outputs sampled 1 ns later.
module tb_act_nz_scanner;

  localparam int ACT_NO = 16;
  localparam int ACT_W  = 4;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ACT_NO-1:0] in_act_zeros;
  logic              in_act_read_en;
  logic [ACT_W-1:0]  in_act_read_addr;
  logic [DATA_W-1:0] in_act_read_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACT_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [ACT_W:0]    nnz_cnt;

  logic [DATA_W-1:0] mem [ACT_NO];

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected emission order and expected read order.
  logic [ACT_W-1:0] exp_q[$];
  logic [ACT_W-1:0] rd_q[$];

  typedef struct {
    logic [15:0] zeros;
    int          mode;       // 0: ready high, 1: ready low T+2..T+5, 2: random ready
    int          repulse;    // cycle offset at which start is re-pulsed, -1 none
    int          exp_done;   // expected done offset, -1 unchecked
    int          exp_first;  // expected first read offset, -1 no read, -2 unchecked
  } vec_t;

  act_nz_scanner #(.ACT_NO(ACT_NO), .ACT_W(ACT_W), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .in_act_zeros     (in_act_zeros),
    .in_act_read_en   (in_act_read_en),
    .in_act_read_addr (in_act_read_addr),
    .in_act_read_data (in_act_read_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_idx          (out_idx),
    .out_data         (out_data),
    .out_last         (out_last),
    .busy             (busy),
    .done             (done),
    .nnz_cnt          (nnz_cnt)
  );

  // Clock and combinational register-file read model.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign in_act_read_data = mem[in_act_read_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < ACT_NO; i++) mem[i] = DATA_W'($urandom_range(0, 65535));
  endtask

  // Drive one scan from cycle T and check every cycle against the scoreboard.
  task automatic run_scan(input logic [15:0] zeros, input int mode, input int repulse,
                          output int done_at, output int first_rd);
    logic [15:0] nz;
    logic        exp_rd;
    int          n;
    nz = ~zeros;
    n  = 0;
    exp_q.delete();
    rd_q.delete();
    for (int i = 0; i < ACT_NO; i++) begin
      if (nz[i]) begin
        exp_q.push_back(ACT_W'(i));
        rd_q.push_back(ACT_W'(i));
        n++;
      end
    end
    fill_mem();
    done_at  = -1;
    first_rd = -1;
    @(negedge clk);
    start        = 1'b1;
    in_act_zeros = zeros;
    out_ready    = 1'b1;
    for (int c = 1; c <= 200 && done_at < 0; c++) begin
      @(negedge clk);
      start        = (c == repulse);
      in_act_zeros = (c == repulse) ? 16'h0000 : 16'($urandom_range(0, 65535));
      case (mode)
        1:       out_ready = !(c >= 2 && c <= 5);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      #1;
      exp_rd = (rd_q.size() > 0) && (!out_valid || out_ready);
      chk("read_en", in_act_read_en, exp_rd);
      if (exp_rd && in_act_read_en) begin
        chk("read_addr", in_act_read_addr, rd_q[0]);
        void'(rd_q.pop_front());
        if (first_rd < 0) first_rd = c;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", out_valid, 1'b0);
        end else begin
          chk("out_idx", out_idx, exp_q[0]);
          chk("out_data", out_data, mem[exp_q[0]]);
          chk("out_last", out_last, exp_q.size() == 1);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        done_at = c;
        chk("all_emitted", exp_q.size(), 0);
        chk("nnz_cnt", nnz_cnt, n);
        chk("busy_at_done", busy, 1'b0);
      end else begin
        chk("busy_in_scan", busy, 1'b1);
      end
    end
    if (done_at < 0) chk("done_timeout", 0, 1);
    // Cycle after completion: pulse gone, nothing pending on the output.
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("done_one_cycle", done, 1'b0);
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_last", out_last, 1'b0);
    chk("nnz_hold", nnz_cnt, n);
  endtask

  vec_t vecs[8];
  int   done_at, first_rd;

  initial begin
    vecs[0] = '{16'hFFFF, 0, -1, 2, -1};
    vecs[1] = '{16'hFFF6, 0, -1, 4, 1};
    vecs[2] = '{16'h0000, 0, -1, 18, 1};
    vecs[3] = '{16'hFFF6, 1, -1, 8, 1};
    vecs[4] = '{16'hFFF6, 0, 2, 4, 1};
    vecs[5] = '{16'h7FFF, 0, -1, 3, 1};
    vecs[6] = '{16'hAAAA, 0, -1, 10, 1};
    vecs[7] = '{16'h0000, 2, -1, -1, -2};

    // Reset block.
    rst          = 1'b1;
    start        = 1'b0;
    in_act_zeros = '0;
    out_ready    = 1'b0;
    fill_mem();
    @(negedge clk);
    start = 1'b1;
    #1;
    chk("rst_read_en", in_act_read_en, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_idx", out_idx, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_nnz", nnz_cnt, 0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    #1;
    chk("post_rst_read_en", in_act_read_en, 1'b0);
    chk("post_rst_busy", busy, 1'b0);

    // Table-driven scans.
    foreach (vecs[k]) begin
      run_scan(vecs[k].zeros, vecs[k].mode, vecs[k].repulse, done_at, first_rd);
      if (vecs[k].exp_done >= 0) chk($sformatf("done_offset_v%0d", k), done_at, vecs[k].exp_done);
      if (vecs[k].exp_first != -2) chk($sformatf("first_read_v%0d", k), first_rd, vecs[k].exp_first);
    end

    // Randomized scans with random backpressure.
    for (int r = 0; r < 8; r++) begin
      run_scan(16'($urandom_range(0, 65535)), 2, -1, done_at, first_rd);
    end

    // Reset in the middle of a scan, then a clean rescan.
    fill_mem();
    @(negedge clk);
    start        = 1'b1;
    in_act_zeros = 16'hFFF6;
    out_ready    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("mid_rst_first_read", in_act_read_addr, 0);
    @(negedge clk);
    #1;
    chk("mid_rst_valid_before", out_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_read_en", in_act_read_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_nnz", nnz_cnt, 0);
    chk("mid_rst_read_en_after", in_act_read_en, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("no_resume_done", done, 1'b0);
      chk("no_resume_read", in_act_read_en, 1'b0);
      chk("no_resume_valid", out_valid, 1'b0);
    end
    run_scan(16'hFFF6, 0, -1, done_at, first_rd);
    chk("rescan_done_offset", done_at, 4);
    chk("rescan_first_read", first_rd, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
